tx_encoder: RTL

//   Backscatter line encoder for the EPC C1G2 tag reply path, directly downstream of the

---
 rtl/tx_encoder_pkg.sv | 39 +++
 rtl/tx_encoder_if.sv | 25 ++
 rtl/tx_encoder_halfcnt.sv | 34 +++
 rtl/tx_encoder.sv | 129 ++++++++++++
 4 files changed

// File: rtl/tx_encoder_pkg.sv
// Shared definitions for the backscatter line encoder: FSM state encoding,
// mode constants and bit-period decode helpers.
package tx_encoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_RUN   = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] M_FM0 = 2'd0;
    localparam logic [1:0] M_M2  = 2'd1;
    localparam logic [1:0] M_M4  = 2'd2;
    localparam logic [1:0] M_M8  = 2'd3;

    // Index of the last half-period of a bit: H-1 with H = 2 (FM0) or 2*M.
    function automatic logic [3:0] half_last(input logic [1:0] m);
        case (m)
            M_FM0:   half_last = 4'd1;
            M_M2:    half_last = 4'd3;
            M_M4:    half_last = 4'd7;
            default: half_last = 4'd15;
        endcase
    endfunction

    // Half-period just before the mid-bit point (H/2 - 1); the mid-bit
    // transition is applied on the half that follows it.
    function automatic logic [3:0] mid_last(input logic [1:0] m);
        case (m)
            M_FM0:   mid_last = 4'd0;
            M_M2:    mid_last = 4'd1;
            M_M4:    mid_last = 4'd3;
            default: mid_last = 4'd7;
        endcase
    endfunction

endpackage

// File: rtl/tx_encoder_if.sv
// Symbol stream and control/status bundle between the reply path and the encoder.
// Handshake: bit_adv acts as ready from the encoder; there is no valid from
// upstream -- in_bit/in_violation/in_last must be valid on every cycle where
// bit_adv=1 and are captured on the rising edge that ends that cycle.
interface tx_encoder_if;
    logic       tx_start;
    logic [1:0] m;
    logic       in_bit;
    logic       in_violation;
    logic       in_last;
    logic       bit_adv;
    logic       mod_out;
    logic       busy;
    logic       tx_done;

    modport master (
        output tx_start, m, in_bit, in_violation, in_last,
        input  bit_adv, mod_out, busy, tx_done
    );

    modport slave (
        input  tx_start, m, in_bit, in_violation, in_last,
        output bit_adv, mod_out, busy, tx_done
    );
endinterface

// File: rtl/tx_encoder_halfcnt.sv
// Half-period counter within a bit, subcarrier toggle and the end-of-bit /
// mid-bit strobes. All strobes refer to the half-period being displayed now.
module tx_encoder_halfcnt
    import tx_encoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [1:0] m_q,
    output logic       sc_next,
    output logic       end_bit,
    output logic       mid_next
);

    logic [3:0] hcnt;
    logic       sc;

    assign end_bit  = run && (hcnt == half_last(m_q));
    assign mid_next = run && !end_bit && (hcnt == mid_last(m_q));
    // Forced to 1 outside a frame so the first displayed half has sc=1.
    assign sc_next  = run ? ~sc : 1'b1;

    // Count half-periods, wrapping at the end of each bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt <= 4'd0;
            sc   <= 1'b0;
        end else begin
            hcnt <= (run && !end_bit) ? hcnt + 4'd1 : 4'd0;
            sc   <= sc_next;
        end
    end

endmodule

// File: rtl/tx_encoder.sv
// FM0 / Miller backscatter line encoder. Pulls one symbol per bit period,
// appends the dummy-1 and reports completion with a sticky flag.
module tx_encoder
    import tx_encoder_pkg::*;
#(
    parameter logic IDLE_LEVEL = 1'b0,
    parameter bit   DUMMY_EN   = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    tx_encoder_if.slave  bus,
    output state_t       dbg_state
);

    state_t     state, state_d;
    logic [1:0] m_q;
    logic       bit_q, last_q, prev_bit;
    logic       level, level_d, phase, phase_d;
    logic       mod_q, mod_d, busy_q, done_q;
    logic       bit_adv, run, run_d, start, enter_dummy, new_sym;
    logic       nb, nv, prev_sym;
    logic       sc_next, end_bit, mid_next;

    tx_encoder_halfcnt u_halfcnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .m_q      (m_q),
        .sc_next  (sc_next),
        .end_bit  (end_bit),
        .mid_next (mid_next)
    );

    assign run         = (state == ST_RUN) || (state == ST_DUMMY);
    assign run_d       = (state_d == ST_RUN) || (state_d == ST_DUMMY);
    assign start       = ((state == ST_IDLE) || (state == ST_DONE)) && bus.tx_start;
    assign enter_dummy = DUMMY_EN && (state == ST_RUN) && end_bit && last_q;
    assign new_sym     = bit_adv || enter_dummy;
    // The dummy symbol is a data-1 without violation.
    assign nb          = bit_adv ? bus.in_bit : 1'b1;
    assign nv          = bit_adv ? bus.in_violation : 1'b0;
    // At a running boundary the outgoing symbol is still in bit_q.
    assign prev_sym    = (state == ST_FETCH) ? prev_bit : bit_q;

    assign bus.bit_adv = bit_adv;
    assign bus.mod_out = mod_q;
    assign bus.busy    = busy_q;
    assign bus.tx_done = done_q;
    assign dbg_state   = state;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_d;
    end

    // Next state and symbol request strobe.
    always_comb begin
        state_d = state;
        bit_adv = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: if (bus.tx_start) state_d = ST_FETCH;
            ST_FETCH: begin
                bit_adv = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (end_bit) begin
                    if (!last_q) bit_adv = 1'b1;
                    else         state_d = DUMMY_EN ? ST_DUMMY : ST_DONE;
                end
            end
            ST_DUMMY: if (end_bit) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Level (FM0) and phase (Miller) for the half-period about to be shown.
    always_comb begin
        level_d = level;
        phase_d = phase;
        if (new_sym) begin
            if (!nv)                     level_d = ~level;
            if (!nb && !prev_sym && !nv) phase_d = ~phase;
        end else if (mid_next) begin
            if (!bit_q) level_d = ~level;
            if (bit_q)  phase_d = ~phase;
        end
        mod_d = (m_q == M_FM0) ? level_d : (sc_next ^ phase_d);
    end

    // Frame control, symbol capture and the registered line output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q      <= M_FM0;
            bit_q    <= 1'b0;
            last_q   <= 1'b0;
            prev_bit <= 1'b1;
            level    <= IDLE_LEVEL;
            phase    <= 1'b0;
            mod_q    <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (start) begin
                m_q      <= bus.m;
                done_q   <= 1'b0;
                busy_q   <= 1'b1;
                level    <= IDLE_LEVEL;
                phase    <= 1'b0;
                prev_bit <= 1'b1;
            end else begin
                level <= level_d;
                phase <= phase_d;
                if (end_bit) prev_bit <= bit_q;
            end
            if (new_sym) begin
                bit_q  <= nb;
                last_q <= bit_adv ? bus.in_last : 1'b1;
            end
            if (run && !run_d) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
            mod_q <= run_d ? mod_d : IDLE_LEVEL;
        end
    end

endmodule
